pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 16, giving the PC and target width in bits.
REQ-002 The block SHALL have the parameter STACK_DEPTH, default 8, giving the number of return-address entries (minimum 2).
REQ-003 The block SHALL have the parameter RESET_VECTOR, default 0, giving the PC value loaded on reset.
REQ-004 The block SHALL have the port sys_clock, input, width 1: system clock, rising-edge active.
REQ-005 The block SHALL have the port reset, input, width 1: reset, synchronous, active-high.
REQ-006 The block SHALL have the port pc_en, input, width 1: advance enable; when 0 all state holds.
REQ-007 The block SHALL have the port op, input, width 3 (pc_op_t): SEQ=0, JUMP=1, BRANCH=2, CALL=3, RET=4; codes 5-7 reserved.
REQ-008 The block SHALL have the port target, input, width ADDR_W: absolute address (JUMP/CALL) or two's-complement offset (BRANCH).
REQ-009 The block SHALL have the port pc, output, width ADDR_W: current instruction address, registered.
REQ-010 The block SHALL have the port depth, output, width $clog2(STACK_DEPTH+1): number of valid stack entries.
REQ-011 The block SHALL have the port overflow, output, width 1: sticky flag, set when a CALL is attempted with the stack full.
REQ-012 The block SHALL have the port underflow, output, width 1: sticky flag, set when a RET is attempted with the stack empty.

Function
REQ-013 All state SHALL update only on the rising edge of sys_clock with pc_en=1; with pc_en=0, pc, the stack, depth and the flags SHALL hold.
REQ-014 On SEQ, pc SHALL become pc+1.
REQ-015 On JUMP, pc SHALL become target.
REQ-016 On BRANCH, pc SHALL become pc + target, with target taken as signed.
REQ-017 On CALL with depth<STACK_DEPTH, pc+1 SHALL be pushed, depth SHALL increment and pc SHALL become target, all in the same cycle.
REQ-018 On RET with depth>0, pc SHALL become the top entry and depth SHALL decrement in the same cycle.
REQ-019 All PC arithmetic SHALL be modulo 2^ADDR_W: max+1 wraps to 0, and a negative branch from 0 wraps high.
REQ-020 CALL pushing from pc=max SHALL store the wrapped value 0.
REQ-021 CALL on a full stack SHALL still set pc to target, discard the push, leave depth unchanged and set overflow.
REQ-022 RET on an empty stack SHALL set pc to pc+1, leave depth at 0 and set underflow.
REQ-023 Reserved op codes SHALL behave as SEQ and SHALL NOT touch the stack or flags.
REQ-024 The stack SHALL be LIFO; the entry order SHALL be preserved across interleaved CALL/RET.
REQ-025 Update latency SHALL be one cycle: the new pc is visible after the enabling edge, and depth and flags change on the same edge.
REQ-026 The RET read of the top entry SHALL use the stack state from before the edge.

Reset
REQ-027 On reset=1 at an edge, pc SHALL load RESET_VECTOR, depth SHALL load 0, and overflow and underflow SHALL load 0, regardless of pc_en and op.
REQ-028 Reset asserted mid-sequence (stack non-empty) SHALL discard all entries; stack RAM contents need not be cleared.
REQ-029 The sticky flags SHALL clear only on reset.

Structure
REQ-030 Package pc_pkg SHALL hold the pc_op_t enum (3-bit) and the op encodings.
REQ-031 The return stack SHALL be a sub-module, return_stack (parameters ADDR_W and STACK_DEPTH; push, pop, top, depth, full, empty).
REQ-032 All next-PC selection SHALL sit in pc_sequencer; return_stack SHALL hold no PC arithmetic.

Verification
REQ-033 The bench SHALL cover: reset then 3 cycles of SEQ with pc_en=1 -> pc = 0,1,2,3; pc_en=0 for 2 cycles -> pc holds 3.
REQ-034 The bench SHALL cover: pc=0x0010, BRANCH with target=0xFFFC -> pc=0x000C; pc=0xFFFF, SEQ -> pc=0x0000.
REQ-035 The bench SHALL cover: pc=0x0100, CALL 0x2000 -> pc=0x2000, depth=1; CALL 0x3000 -> depth=2; RET -> pc=0x2001; RET -> pc=0x0101, depth=0.
REQ-036 The bench SHALL cover: 8 CALLs, then a 9th CALL 0x4000 -> pc=0x4000, depth=8, overflow=1; then 8 RETs return the saved addresses in reverse order.
REQ-037 The bench SHALL cover: RET with depth=0 at pc=0x0050 -> pc=0x0051, underflow=1; the flag stays 1 through 5 more SEQ cycles.
REQ-038 The bench SHALL cover: depth=3 and reset asserted together with a CALL -> pc=RESET_VECTOR, depth=0, flags=0; a following RET -> underflow=1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer.
// Holds the pc_op_t operation encoding used by pc_sequencer.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_SEQ    = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } pc_op_t;

    localparam int OP_W = 3;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; storage and occupancy only, no PC math.
// Ports: sys_clock, reset, push, pop, push_data -> top, depth, full, empty.
module return_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic                               sys_clock,
    input  logic                               reset,
    input  logic                               push,
    input  logic                               pop,
    input  logic [ADDR_W-1:0]                  push_data,
    output logic [ADDR_W-1:0]                  top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty
);

    localparam int IW = $clog2(STACK_DEPTH);
    localparam int DW = $clog2(STACK_DEPTH+1);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [DW-1:0]     count;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == DW'(STACK_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Index truncation is safe: a write never happens when full,
    // and the read index only matters when not empty.
    assign wr_idx = IW'(count);
    assign rd_idx = IW'(count - DW'(1));
    assign top    = mem[rd_idx];
    assign depth  = count;

    // Entries are not cleared on reset; count alone defines validity.
    always_ff @(posedge sys_clock) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            count <= '0;
        end else if (do_push) begin
            count <= count + DW'(1);
        end else if (do_pop) begin
            count <= count - DW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with jump/branch/call/return and a return stack.
// Ports: sys_clock, reset, pc_en, op, target -> pc, depth, overflow, underflow.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = 16,
    parameter int                STACK_DEPTH  = 8,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic                               sys_clock,
    input  logic                               reset,
    input  logic                               pc_en,
    input  logic [OP_W-1:0]                    op,
    input  logic [ADDR_W-1:0]                  target,
    output logic [ADDR_W-1:0]                  pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               overflow,
    output logic                               underflow
);

    pc_op_t            op_t;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;
    logic              push_req;
    logic              pop_req;
    logic              set_ovf;
    logic              set_unf;
    logic              advance;

    assign op_t    = pc_op_t'(op);
    assign pc_inc  = pc + ADDR_W'(1);
    assign advance = pc_en && !reset;

    // Two's-complement add is identical to unsigned add modulo 2^ADDR_W,
    // so BRANCH needs no sign extension.
    always_comb begin
        next_pc  = pc_inc;
        push_req = 1'b0;
        pop_req  = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        case (op_t)
            OP_JUMP: begin
                next_pc = target;
            end
            OP_BRANCH: begin
                next_pc = pc + target;
            end
            OP_CALL: begin
                next_pc  = target;
                push_req = !stk_full;
                set_ovf  = stk_full;
            end
            OP_RET: begin
                if (!stk_empty) begin
                    next_pc = stk_top;
                    pop_req = 1'b1;
                end else begin
                    set_unf = 1'b1;
                end
            end
            default: begin
                next_pc = pc_inc;
            end
        endcase
    end

    return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .sys_clock (sys_clock),
        .reset     (reset),
        .push      (advance && push_req),
        .pop       (advance && pop_req),
        .push_data (pc_inc),
        .top       (stk_top),
        .depth     (depth),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            pc        <= RESET_VECTOR;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (pc_en) begin
            pc <= next_pc;
            if (set_ovf) begin
                overflow <= 1'b1;
            end
            if (set_unf) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: reference model feeds a queue,
// a monitor pops and compares after every rising edge.
module tb_pc_sequencer;

    logic        sys_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        pc_en     = 1'b0;
    logic [2:0]  op        = 3'd0;
    logic [15:0] target    = 16'h0;
    logic [15:0] pc;
    logic [3:0]  depth;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_pass   = 0;
    int n_step   = 0;

    typedef struct {
        logic [15:0] pc;
        logic [3:0]  depth;
        logic        ovf;
        logic        unf;
        int          id;
    } exp_t;

    exp_t exp_q[$];

    // Reference state
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_ovf;
    logic        m_unf;

    pc_sequencer #(
        .ADDR_W       (16),
        .STACK_DEPTH  (8),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .pc_en     (pc_en),
        .op        (op),
        .target    (target),
        .pc        (pc),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic model(input bit r, input bit en,
                         input logic [2:0] o,
                         input logic [15:0] t);
        logic [15:0] ret;
        if (r) begin
            m_pc  = 16'h0000;
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_stk.delete();
        end else if (en) begin
            ret = m_pc + 16'd1;
            case (o)
                3'd1: m_pc = t;
                3'd2: m_pc = m_pc + t;
                3'd3: begin
                    if (m_stk.size() < 8) m_stk.push_back(ret);
                    else m_ovf = 1'b1;
                    m_pc = t;
                end
                3'd4: begin
                    if (m_stk.size() > 0) begin
                        m_pc = m_stk.pop_back();
                    end else begin
                        m_unf = 1'b1;
                        m_pc  = ret;
                    end
                end
                default: m_pc = ret;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit en,
                        input logic [2:0] o,
                        input logic [15:0] t);
        exp_t e;
        @(negedge sys_clock);
        reset  = r;
        pc_en  = en;
        op     = o;
        target = t;
        model(r, en, o, t);
        n_step++;
        e.pc    = m_pc;
        e.depth = 4'(m_stk.size());
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.id    = n_step;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int id,
                         input logic [15:0] act,
                         input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s step %0d: got %h, expected %h",
                      name, id, act, req);
    endtask

    // Monitor: one registered update per edge, compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", e.id, pc, e.pc);
                check("depth", e.id, 16'(depth), 16'(e.depth));
                check("overflow", e.id, 16'(overflow), 16'(e.ovf));
                check("underflow", e.id, 16'(underflow), 16'(e.unf));
            end
        end
    end

    initial begin
        m_pc  = 16'h0;
        m_ovf = 1'b0;
        m_unf = 1'b0;

        // Reset, three SEQ, then two held cycles
        step(1, 0, 3'd0, 16'h0);
        repeat (3) step(0, 1, 3'd0, 16'h0);
        repeat (2) step(0, 0, 3'd3, 16'h1234);

        // Negative branch and wrap at max
        step(0, 1, 3'd1, 16'h0010);
        step(0, 1, 3'd2, 16'hFFFC);
        step(0, 1, 3'd1, 16'hFFFF);
        step(0, 1, 3'd0, 16'h0);
        step(0, 1, 3'd2, 16'hFFFF);

        // Call from max stores wrapped 0
        step(0, 1, 3'd1, 16'hFFFF);
        step(0, 1, 3'd3, 16'h0700);
        step(0, 1, 3'd4, 16'h0);

        // Nested call/return
        step(0, 1, 3'd1, 16'h0100);
        step(0, 1, 3'd3, 16'h2000);
        step(0, 1, 3'd3, 16'h3000);
        step(0, 1, 3'd4, 16'h0);
        step(0, 1, 3'd4, 16'h0);

        // Fill the stack, overflow, then unwind
        step(1, 1, 3'd0, 16'h0);
        step(0, 1, 3'd1, 16'h1000);
        for (int i = 0; i < 8; i++)
            step(0, 1, 3'd3, 16'h1000 + 16'(i * 16'h0100));
        step(0, 1, 3'd3, 16'h4000);
        for (int i = 0; i < 8; i++)
            step(0, 1, 3'd4, 16'h0);

        // Underflow is sticky
        step(1, 1, 3'd0, 16'h0);
        step(0, 1, 3'd1, 16'h0050);
        step(0, 1, 3'd4, 16'h0);
        repeat (5) step(0, 1, 3'd0, 16'h0);

        // Reset wins over a CALL with a non-empty stack
        step(1, 1, 3'd0, 16'h0);
        for (int i = 0; i < 3; i++)
            step(0, 1, 3'd3, 16'h0200 + 16'(i));
        step(1, 1, 3'd3, 16'h5555);
        step(0, 1, 3'd4, 16'h0);

        // Reserved codes leave stack and flags alone
        step(1, 1, 3'd0, 16'h0);
        step(0, 1, 3'd3, 16'h0300);
        for (int i = 5; i < 8; i++)
            step(0, 1, 3'(i), 16'hBEEF);
        step(0, 1, 3'd4, 16'h0);

        // Random traffic, biased toward stack ops
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  o;
            logic [15:0] t;
            bit          en;
            bit          r;
            o  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0)
                o = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4;
            t  = 16'($urandom);
            en = ($urandom_range(0, 4) != 0);
            r  = ($urandom_range(0, 60) == 0);
            step(r, en, o, t);
        end

        // Drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge sys_clock);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
